// File: rtl/cte_if.sv
// Stream bus for the colour transform engine: input byte/pixel with busy back-pressure,
// output byte/pixel qualified by out_valid.
interface cte_if;
  logic        op_mode;
  logic        in_en;
  logic [7:0]  yuv_in;
  logic [23:0] rgb_in;
  logic        busy;
  logic        out_valid;
  logic [23:0] rgb_out;
  logic [7:0]  yuv_out;

  modport master (
    output op_mode, in_en, yuv_in, rgb_in,
    input  busy, out_valid, rgb_out, yuv_out
  );

  modport slave (
    input  op_mode, in_en, yuv_in, rgb_in,
    output busy, out_valid, rgb_out, yuv_out
  );
endinterface

// File: rtl/cte.sv
// Colour transform engine: YUV 4:2:2 bytes -> RGB pixels (op_mode=0) or
// RGB pixels -> YUV 4:2:2 bytes (op_mode=1), all arithmetic in eighths with round half up.
module cte (
  input  logic clk,
  input  logic reset,
  cte_if.slave bus
);

  typedef enum logic [1:0] {PhU, PhY0, PhV, PhY1} phase_e;

  phase_e      phase_q, phase_d;
  logic [7:0]  u_q, v_q, y0_q;
  logic        par_q, par_d;
  logic        busy_q;
  logic        out_valid_q;
  logic [23:0] rgb_q, rgb_d;
  logic [7:0]  yuv_q, yuv_d;
  logic [7:0]  q_q [2];
  logic [7:0]  q_d [2];
  logic [1:0]  cnt_q, cnt_d;

  logic accept;
  logic ov0, yv;

  assign accept = bus.in_en & ~busy_q;

  // Round an eighths value half up, then saturate to an unsigned byte.
  function automatic logic [7:0] sat_u8(input logic signed [13:0] x8);
    logic signed [13:0] r;
    r = (x8 + 14'sd4) >>> 3;
    if (r < 14'sd0) return 8'h00;
    if (r > 14'sd255) return 8'hff;
    return r[7:0];
  endfunction

  // Round an eighths value half up, then saturate to a signed byte.
  function automatic logic [7:0] sat_s8(input logic signed [13:0] x8);
    logic signed [13:0] r;
    r = (x8 + 14'sd4) >>> 3;
    if (r < -14'sd128) return 8'h80;
    if (r > 14'sd127) return 8'h7f;
    return r[7:0];
  endfunction

  // YUV -> RGB: on V the even pixel uses the stored Y0; on Y1 the stored V is reused.
  logic [7:0]         y_sel, v_sel;
  logic signed [13:0] y14, u14, v14;
  logic signed [13:0] r8, g8, b8;

  always_comb begin
    y_sel = (phase_q == PhV) ? y0_q : bus.yuv_in;
    v_sel = (phase_q == PhV) ? bus.yuv_in : v_q;
  end

  assign y14 = {6'd0, y_sel};
  assign u14 = {{6{u_q[7]}}, u_q};
  assign v14 = {{6{v_sel[7]}}, v_sel};
  assign r8  = y14 * 14'sd8 + v14 * 14'sd13;
  assign g8  = y14 * 14'sd8 - u14 * 14'sd2 - v14 * 14'sd6;
  assign b8  = y14 * 14'sd8 + u14 * 14'sd16;

  // RGB -> YUV
  logic signed [13:0] rr, gg, bb;
  logic signed [13:0] ym, um, vm;
  logic [7:0]         ym8, um8, vm8;

  assign rr  = {6'd0, bus.rgb_in[23:16]};
  assign gg  = {6'd0, bus.rgb_in[15:8]};
  assign bb  = {6'd0, bus.rgb_in[7:0]};
  assign ym  = rr * 14'sd2 + gg * 14'sd5 + bb;
  assign um  = -rr - gg * 14'sd2 + bb * 14'sd3;
  assign vm  = rr * 14'sd4 - gg * 14'sd3 - bb;
  assign ym8 = sat_u8(ym);
  assign um8 = sat_s8(um);
  assign vm8 = sat_s8(vm);

  // Mode 0 phase tracking and pixel output.
  always_comb begin
    phase_d = phase_q;
    par_d   = par_q;
    rgb_d   = rgb_q;
    ov0     = 1'b0;
    if (accept && !bus.op_mode) begin
      unique case (phase_q)
        PhU:  phase_d = PhY0;
        PhY0: phase_d = PhV;
        PhV: begin
          phase_d = PhY1;
          ov0     = 1'b1;
        end
        PhY1: begin
          phase_d = PhU;
          ov0     = 1'b1;
        end
      endcase
    end
    if (ov0) rgb_d = {sat_u8(r8), sat_u8(g8), sat_u8(b8)};
    if (accept && bus.op_mode) par_d = ~par_q;
  end

  // Mode 1 byte sequencer: pending bytes followed by newly produced ones; the head goes out
  // this edge, the rest wait. The one-cycle busy keeps at most two bytes pending.
  logic [7:0] cand [5];
  logic [2:0] n;

  always_comb begin
    for (int i = 0; i < 5; i++) cand[i] = 8'h00;
    cand[0] = q_q[0];
    cand[1] = q_q[1];
    n       = {1'b0, cnt_q};
    if (accept && bus.op_mode) begin
      if (!par_q) begin
        cand[n]         = um8;
        cand[n + 3'd1]  = ym8;
        cand[n + 3'd2]  = vm8;
        n               = n + 3'd3;
      end else begin
        cand[n] = ym8;
        n       = n + 3'd1;
      end
    end
    q_d   = q_q;
    cnt_d = cnt_q;
    yuv_d = yuv_q;
    yv    = 1'b0;
    if (n != 3'd0) begin
      yv     = 1'b1;
      yuv_d  = cand[0];
      q_d[0] = cand[1];
      q_d[1] = cand[2];
      cnt_d  = 2'(n - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PhU;
      par_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rgb_q       <= 24'h0;
      yuv_q       <= 8'h0;
      q_q[0]      <= 8'h0;
      q_q[1]      <= 8'h0;
      cnt_q       <= 2'd0;
      u_q         <= 8'h0;
      v_q         <= 8'h0;
      y0_q        <= 8'h0;
    end else begin
      phase_q     <= phase_d;
      par_q       <= par_d;
      busy_q      <= accept & bus.op_mode;
      out_valid_q <= ov0 | yv;
      rgb_q       <= rgb_d;
      yuv_q       <= yuv_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      if (accept && !bus.op_mode) begin
        case (phase_q)
          PhU:     u_q  <= bus.yuv_in;
          PhY0:    y0_q <= bus.yuv_in;
          PhV:     v_q  <= bus.yuv_in;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rgb_out   = rgb_q;
  assign bus.yuv_out   = yuv_q;

endmodule

// File: tb/tb_cte.sv
// Scoreboard bench for cte: stimulus pushes expected results from a real-valued colour model,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_cte;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cte_if bus ();
  cte dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          due;
    bit          is_rgb;
    logic [23:0] rgb;
    logic [7:0]  yuv;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_due = -100;
  int          last_acc = -100;
  bit          mon_en = 1'b0;
  bit          m_mode = 1'b0;
  bit          m_par = 1'b0;
  int          m_ph = 0;
  int          m_u, m_v, m_y0;
  int          n_valid = 0;
  logic [23:0] hold_rgb = 24'h0;
  logic [7:0]  hold_yuv = 8'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rnd(input real x);
    return $rtoi($floor(x + 0.5));
  endfunction

  function automatic logic [7:0] clip_u(input int r);
    if (r < 0) return 8'h00;
    if (r > 255) return 8'hff;
    return 8'(r);
  endfunction

  function automatic logic [7:0] clip_s(input int r);
    if (r < -128) return 8'h80;
    if (r > 127) return 8'h7f;
    return 8'(r);
  endfunction

  function automatic logic [23:0] pix(input int y, input int u, input int v);
    return {clip_u(rnd(y + 1.625 * v)), clip_u(rnd(y - 0.25 * u - 0.75 * v)),
            clip_u(rnd(y + 2.0 * u))};
  endfunction

  task automatic push(input int due_min, input bit is_rgb, input logic [23:0] rgb,
                      input logic [7:0] yuv);
    exp_t e;
    e.due    = (due_min > last_due) ? due_min : last_due + 1;
    e.is_rgb = is_rgb;
    e.rgb    = rgb;
    e.yuv    = yuv;
    last_due = e.due;
    sb.push_back(e);
  endtask

  task automatic model_accept(input int a, input logic [7:0] b, input logic [23:0] p);
    int r, g, bl;
    if (!m_mode) begin
      case (m_ph)
        0: m_u = int'($signed(b));
        1: m_y0 = int'(b);
        2: begin
          m_v = int'($signed(b));
          push(a, 1'b1, pix(m_y0, m_u, m_v), 8'h0);
        end
        default: push(a, 1'b1, pix(int'(b), m_u, m_v), 8'h0);
      endcase
      m_ph = (m_ph + 1) % 4;
    end else begin
      r  = int'(p[23:16]);
      g  = int'(p[15:8]);
      bl = int'(p[7:0]);
      if (!m_par) begin
        push(a, 1'b0, 24'h0, clip_s(rnd(-0.125 * r - 0.25 * g + 0.375 * bl)));
        push(a + 1, 1'b0, 24'h0, clip_u(rnd(0.25 * r + 0.625 * g + 0.125 * bl)));
        push(a + 2, 1'b0, 24'h0, clip_s(rnd(0.5 * r - 0.375 * g - 0.125 * bl)));
      end else begin
        push(a, 1'b0, 24'h0, clip_u(rnd(0.25 * r + 0.625 * g + 0.125 * bl)));
      end
      m_par = !m_par;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [23:0] p);
    int tries;
    tries = 0;
    @(negedge clk);
    bus.in_en  = 1'b1;
    bus.yuv_in = b;
    bus.rgb_in = p;
    while (bus.busy === 1'b1) begin
      tries++;
      if (tries > 4) begin
        total++;
        bad++;
        $display("FAIL busy_stuck: busy=1 for %0d cycles, expected release within 4", tries);
        bus.in_en = 1'b0;
        return;
      end
      @(negedge clk);
    end
    last_acc = cyc + 1;
    model_accept(cyc + 1, b, p);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_en  = 1'b0;
      bus.yuv_in = 8'($urandom);
      bus.rgb_in = 24'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en    = 1'b0;
    bus.in_en = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    sb.delete();
    last_due = -100;
    last_acc = -100;
    m_ph     = 0;
    m_par    = 1'b0;
    hold_rgb = 24'h0;
    hold_yuv = 8'h0;
    mon_en   = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle(1);
    while (sb.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(bus.busy), 32'(m_mode && (last_acc == cyc)));
      if (bus.out_valid === 1'b1) begin
        n_valid++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output: out_valid=1 rgb_out=%h yuv_out=%h, expected no output",
                   bus.rgb_out, bus.yuv_out);
        end else begin
          mon_e = sb.pop_front();
          check("latency", 32'(cyc), 32'(mon_e.due));
          if (mon_e.is_rgb) begin
            check("rgb_out", 32'(bus.rgb_out), 32'(mon_e.rgb));
            check("yuv_hold", 32'(bus.yuv_out), 32'(hold_yuv));
            hold_rgb = mon_e.rgb;
          end else begin
            check("yuv_out", 32'(bus.yuv_out), 32'(mon_e.yuv));
            check("rgb_hold", 32'(bus.rgb_out), 32'(hold_rgb));
            hold_yuv = mon_e.yuv;
          end
        end
      end else begin
        check("out_valid", 32'(bus.out_valid), 32'h0);
        check("rgb_hold", 32'(bus.rgb_out), 32'(hold_rgb));
        check("yuv_hold", 32'(bus.yuv_out), 32'(hold_yuv));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op_mode = 1'b0;
    bus.in_en   = 1'b0;
    bus.yuv_in  = 8'h0;
    bus.rgb_in  = 24'h0;
    m_mode      = 1'b0;
    do_reset();
    idle(8);

    // Directed YUV->RGB: grey, saturation, negative chroma
    send(8'h00, 24'($urandom)); send(8'h80, 24'($urandom));
    send(8'h00, 24'($urandom)); send(8'h40, 24'($urandom));
    send(8'h7f, 24'($urandom)); send(8'hff, 24'($urandom));
    send(8'h7f, 24'($urandom)); send(8'h00, 24'($urandom));
    send(8'h80, 24'($urandom)); send(8'h10, 24'($urandom));
    send(8'h80, 24'($urandom)); send(8'h10, 24'($urandom));
    drain();

    // in_en gaps keep the phase
    repeat (16) begin
      send(8'($urandom), 24'($urandom));
      idle($urandom_range(0, 3));
    end
    drain();

    // Reset mid-pixel discards the partial U/Y
    send(8'h55, 24'h0); send(8'h99, 24'h0);
    do_reset();
    idle(4);
    send(8'hf0, 24'h0); send(8'h20, 24'h0); send(8'h30, 24'h0); send(8'he0, 24'h0);
    drain();

    // Long continuous stream plus a trailing lone U byte
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 1000; i++) send(8'($urandom), 24'($urandom));
    send(8'($urandom), 24'($urandom));
    idle(4);
    drain();
    check("pixel_count", 32'(n_valid), 32'd500);

    // RGB->YUV: white then black, then random with gaps
    do_reset();
    bus.op_mode = 1'b1;
    m_mode      = 1'b1;
    idle(2);
    send(8'h0, 24'hffffff);
    send(8'h0, 24'h000000);
    idle(6);
    drain();
    repeat (200) begin
      send(8'($urandom), 24'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
